// File: rtl/pwm_decoder_pkg.sv
// Shared types for the PWM decoder: measurement FSM state encoding and the
// default amplitude width of the PWM link.
package pwm_decoder_pkg;

   localparam int unsigned DEF_XLEN = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HIGH  = 2'd1,
      ST_LOW   = 2'd2,
      ST_STUCK = 2'd3
   } pwm_state_e;

endpackage : pwm_decoder_pkg

// File: rtl/pwm_decoder_sat_counter.sv
// Saturating up-counter: synchronous reset to 0, clear loads 1, enable counts
// up and sticks at all-ones; sat_o flags the all-ones value.
module pwm_decoder_sat_counter #(
   parameter int W = 3
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clr_i,
   input  logic         en_i,
   output logic [W-1:0] cnt_o,
   output logic         sat_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   assign sat_o = &cnt_q;
   assign cnt_o = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = W'(1);
      end else if (en_i && !sat_o) begin
         cnt_d = cnt_q + W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule : pwm_decoder_sat_counter

// File: rtl/pwm_decoder.sv
// Recovers high-time (ampl) and period (duty) from a synchronous PWM waveform,
// publishing one registered measurement per period and flagging stuck levels.
module pwm_decoder
   import pwm_decoder_pkg::*;
#(
   parameter int XLEN = DEF_XLEN
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            signal_i,
   output logic [XLEN-1:0] ampl_o,
   output logic [XLEN:0]   duty_o,
   output logic            valid_o,
   output logic            stuck_o,
   output logic            err_o
);

   pwm_state_e      state_q, state_d;
   logic            prev_q;
   logic            ovf_q, ovf_d;
   logic [XLEN-1:0] ampl_q, ampl_d;
   logic [XLEN:0]   duty_q, duty_d;
   logic            valid_q, valid_d;
   logic            stuck_q, stuck_d;
   logic            err_q, err_d;

   logic            rise, fall, go_stuck;
   logic            h_clr, h_en, h_sat;
   logic            p_clr, p_en, p_sat;
   logic [XLEN-1:0] hcnt;
   logic [XLEN:0]   pcnt;

   assign rise = signal_i & ~prev_q;
   assign fall = ~signal_i & prev_q;

   pwm_decoder_sat_counter #(.W(XLEN)) u_hcnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (h_clr),
      .en_i  (h_en),
      .cnt_o (hcnt),
      .sat_o (h_sat)
   );

   pwm_decoder_sat_counter #(.W(XLEN + 1)) u_pcnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (p_clr),
      .en_i  (p_en),
      .cnt_o (pcnt),
      .sat_o (p_sat)
   );

   always_comb begin
      state_d  = state_q;
      ovf_d    = ovf_q;
      ampl_d   = ampl_q;
      duty_d   = duty_q;
      stuck_d  = stuck_q;
      err_d    = err_q;
      valid_d  = 1'b0;
      go_stuck = 1'b0;
      h_clr    = 1'b0;
      h_en     = 1'b0;
      p_clr    = 1'b0;
      p_en     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (rise) begin
               state_d = ST_HIGH;
               h_clr   = 1'b1;
               p_clr   = 1'b1;
               ovf_d   = 1'b0;
            end else if (p_sat) begin
               go_stuck = 1'b1;
            end else begin
               p_en = 1'b1;
            end
         end
         ST_HIGH: begin
            // A full pcnt here means the period cannot close within DMAX.
            if (p_sat) begin
               go_stuck = 1'b1;
            end else if (signal_i) begin
               h_en = 1'b1;
               p_en = 1'b1;
               if (h_sat) begin
                  ovf_d = 1'b1;
               end else begin
                  ovf_d = ovf_q;
               end
            end else begin
               state_d = ST_LOW;
               p_en    = 1'b1;
            end
         end
         ST_LOW: begin
            if (rise) begin
               valid_d = 1'b1;
               ampl_d  = hcnt;
               duty_d  = pcnt;
               err_d   = ovf_q;
               stuck_d = 1'b0;
               ovf_d   = 1'b0;
               h_clr   = 1'b1;
               p_clr   = 1'b1;
               state_d = ST_HIGH;
            end else if (p_sat) begin
               go_stuck = 1'b1;
            end else begin
               p_en = 1'b1;
            end
         end
         ST_STUCK: begin
            if (rise) begin
               state_d = ST_HIGH;
               h_clr   = 1'b1;
               p_clr   = 1'b1;
               ovf_d   = 1'b0;
            end else if (fall) begin
               state_d = ST_IDLE;
               p_clr   = 1'b1;
            end else begin
               state_d = ST_STUCK;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (go_stuck) begin
         valid_d = 1'b1;
         stuck_d = 1'b1;
         ampl_d  = signal_i ? '1 : '0;
         duty_d  = '0;
         err_d   = 1'b0;
         state_d = ST_STUCK;
      end else begin
         state_d = state_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         prev_q  <= 1'b0;
         ovf_q   <= 1'b0;
         ampl_q  <= '0;
         duty_q  <= '0;
         valid_q <= 1'b0;
         stuck_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         prev_q  <= signal_i;
         ovf_q   <= ovf_d;
         ampl_q  <= ampl_d;
         duty_q  <= duty_d;
         valid_q <= valid_d;
         stuck_q <= stuck_d;
         err_q   <= err_d;
      end
   end

   assign ampl_o  = ampl_q;
   assign duty_o  = duty_q;
   assign valid_o = valid_q;
   assign stuck_o = stuck_q;
   assign err_o   = err_q;

endmodule : pwm_decoder

// File: tb/tb_pwm_decoder.sv
// Bench for pwm_decoder: a run-length model of the PWM measurement is compared
// against the DUT every cycle; directed scenarios pin the model with literals.
module tb_pwm_decoder;

   localparam int XLEN = 3;
   localparam int AMAX = 7;
   localparam int DMAX = 15;
   localparam int M_WAIT = 0;
   localparam int M_MEAS = 1;
   localparam int M_CONST = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sig = 1'b0;
   logic [2:0] ampl;
   logic [3:0] duty;
   logic       valid, stuck, err;

   always #5 clk = ~clk;

   pwm_decoder #(.XLEN(XLEN)) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .signal_i (sig),
      .ampl_o   (ampl),
      .duty_o   (duty),
      .valid_o  (valid),
      .stuck_o  (stuck),
      .err_o    (err)
   );

   int total = 0;
   int bad = 0;
   bit chk_en = 1'b0;
   int phase = 0;

   // model state: unbounded run lengths since the current period start
   int mode = M_WAIT;
   int plen = 0;
   int hlen = 0;
   bit mprev = 1'b0;
   bit m_rise, m_fall;
   bit e_valid = 1'b0, e_stuck = 1'b0, e_err = 1'b0;
   logic [2:0] e_ampl = 3'd0;
   logic [3:0] e_duty = 4'd0;
   int samp = 0, pub_count = 0;
   int first_samp = 0, first_ampl = 0, first_duty = 0;
   int first_stuck = 0, first_err = 0;
   int last_samp = 0, last_ampl = 0, last_duty = 0, last_stuck = 0, last_err = 0;

   function automatic void pub(int a, int d, bit s, bit e);
      e_valid = 1'b1;
      e_ampl  = 3'(a);
      e_duty  = 4'(d);
      e_stuck = s;
      e_err   = e;
      pub_count++;
      if (pub_count == 1) begin
         first_samp = samp; first_ampl = a; first_duty = d;
         first_stuck = int'(s); first_err = int'(e);
      end
      last_samp = samp; last_ampl = a; last_duty = d;
      last_stuck = int'(s); last_err = int'(e);
   endfunction

   function automatic void go_const();
      pub(sig ? AMAX : 0, 0, 1'b1, 1'b0);
      mode = M_CONST;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         mode = M_WAIT; plen = 0; hlen = 0; mprev = 1'b0;
         e_valid = 1'b0; e_stuck = 1'b0; e_err = 1'b0; e_ampl = 3'd0; e_duty = 4'd0;
         samp = 0; pub_count = 0; first_samp = 0; last_samp = 0;
      end else begin
         m_rise = sig & ~mprev;
         m_fall = ~sig & mprev;
         samp++;
         e_valid = 1'b0;
         case (mode)
            M_WAIT: begin
               if (m_rise) begin
                  mode = M_MEAS; plen = 1; hlen = 1;
               end else begin
                  plen++;
                  if (plen > DMAX) go_const();
               end
            end
            M_MEAS: begin
               if (m_rise) begin
                  pub((hlen > AMAX) ? AMAX : hlen, plen, 1'b0, hlen > AMAX);
                  plen = 1; hlen = 1;
               end else begin
                  plen++;
                  if (sig) hlen++;
                  if (plen > DMAX) go_const();
               end
            end
            default: begin
               if (m_rise) begin
                  mode = M_MEAS; plen = 1; hlen = 1;
               end else if (m_fall) begin
                  mode = M_WAIT; plen = 1;
               end
            end
         endcase
         mprev = sig;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         total++;
         if ({valid, stuck, err, ampl, duty} !== {e_valid, e_stuck, e_err, e_ampl, e_duty}) begin
            bad++;
            $display("FAIL cycle_cmp t=%0t got v=%b s=%b e=%b a=%0d d=%0d want v=%b s=%b e=%b a=%0d d=%0d",
                     $time, valid, stuck, err, ampl, duty, e_valid, e_stuck, e_err, e_ampl, e_duty);
         end
      end
   end

   task automatic check(string name, int act, int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      sig = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      phase = 0;
   endtask

   task automatic drive(bit v, int n);
      for (int i = 0; i < n; i++) begin
         sig = v;
         @(negedge clk);
      end
   endtask

   task automatic run_pwm(int a, int d, int n);
      for (int i = 0; i < n; i++) begin
         sig = (phase < a);
         phase = (phase + 1) % d;
         @(negedge clk);
      end
   endtask

   initial begin
      do_reset();
      chk_en = 1'b1;
      check("reset_valid", int'(valid), 0);
      check("reset_ampl", int'(ampl), 0);
      check("reset_duty", int'(duty), 0);
      check("reset_flags", int'({stuck, err}), 0);

      // ampl=4 duty=7: publishes at samples 8,15,22,29
      run_pwm(4, 7, 30);
      check("p47_first_samp", first_samp, 8);
      check("p47_first_ampl", first_ampl, 4);
      check("p47_first_duty", first_duty, 7);
      check("p47_first_flags", first_stuck + first_err, 0);
      check("p47_count", pub_count, 4);
      check("p47_last_samp", last_samp, 29);

      // constant low
      do_reset();
      run_pwm(0, 7, 56);
      check("c0_samp", first_samp, 16);
      check("c0_stuck", first_stuck, 1);
      check("c0_ampl", first_ampl, 0);
      check("c0_count", pub_count, 1);

      // constant high
      do_reset();
      run_pwm(7, 7, 30);
      check("c1_samp", first_samp, 16);
      check("c1_stuck", first_stuck, 1);
      check("c1_ampl", first_ampl, 7);
      check("c1_duty", first_duty, 0);
      check("c1_count", pub_count, 1);

      // overrange high-time
      do_reset();
      drive(1'b1, 9); drive(1'b0, 3); drive(1'b1, 2);
      check("ovf_samp", first_samp, 13);
      check("ovf_ampl", first_ampl, 7);
      check("ovf_duty", first_duty, 12);
      check("ovf_err", first_err, 1);

      // high-time exactly AMAX is not overrange
      do_reset();
      drive(1'b1, 7); drive(1'b0, 2); drive(1'b1, 1);
      check("amax_ampl", first_ampl, 7);
      check("amax_duty", first_duty, 9);
      check("amax_err", first_err, 0);

      // period exactly DMAX, then DMAX+1
      do_reset();
      drive(1'b1, 5); drive(1'b0, 10); drive(1'b1, 1);
      check("dmax_samp", first_samp, 16);
      check("dmax_duty", first_duty, 15);
      check("dmax_stuck", first_stuck, 0);
      do_reset();
      drive(1'b1, 5); drive(1'b0, 11);
      check("dmax1_samp", first_samp, 16);
      check("dmax1_stuck", first_stuck, 1);
      check("dmax1_ampl", first_ampl, 0);

      // amplitude change mid-period
      do_reset();
      run_pwm(4, 7, 23);
      run_pwm(2, 7, 30);
      check("chg_ampl", last_ampl, 2);
      check("chg_duty", last_duty, 7);
      check("chg_stuck", last_stuck, 0);

      // recovery from stuck low
      do_reset();
      drive(1'b0, 20);
      phase = 0;
      run_pwm(4, 7, 8);
      check("rec_count", pub_count, 2);
      check("rec_samp", last_samp, 28);
      check("rec_ampl", last_ampl, 4);
      check("rec_duty", last_duty, 7);

      // reset while high
      do_reset();
      run_pwm(4, 7, 10);
      rst = 1'b1;
      @(negedge clk);
      check("rsth_valid", int'(valid), 0);
      check("rsth_ampl", int'(ampl), 0);
      check("rsth_duty", int'(duty), 0);
      rst = 1'b0;
      phase = 0;
      run_pwm(4, 7, 9);
      check("rsth_samp", first_samp, 8);
      check("rsth_count", pub_count, 1);

      // random level runs with occasional resets
      do_reset();
      for (int s = 0; s < 250; s++) begin
         if ($urandom_range(0, 39) == 0) begin
            do_reset();
         end
         drive(1'(s % 2), int'($urandom_range(1, 18)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_pwm_decoder
